// File: rtl/dual_port_memory.sv
// dual_port_memory: fetch + data port word memory with self-initialising clear/boot sequencer.
// Optional MEM_WRITE_BYPASS_EN forwards same-cycle write data to colliding reads.
module dual_port_memory #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int READ_LAT = 1
) (
  input  logic              CLK,
  input  logic              reset,
  output logic              ready,
  input  logic              IF_REQ,
  input  logic [15:0]       IF_ADDR,
  output logic [DATA_W-1:0] IF_DATA,
  output logic              IF_VALID,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [15:0]       ADDR,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_valid,
  output logic              addr_err
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [1:0] {CLEAR, BOOT, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx, if_idx, d_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] boot_word, if_rd, d_rd;
  logic run, if_oor, d_oor, we, if_fwd, d_fwd;
  logic [READ_LAT-1:0] iv, dv;
  logic [DATA_W-1:0] id [READ_LAT];
  logic [DATA_W-1:0] dd [READ_LAT];
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("READ_LAT must be 1 or 2");
  end
  assign run = state == RUN;
  assign ready = run;
  assign if_idx = IF_ADDR[ADDR_W-1:0];
  assign d_idx = ADDR[ADDR_W-1:0];
  assign if_oor = (IF_ADDR >> ADDR_W) != 16'd0;
  assign d_oor = (ADDR >> ADDR_W) != 16'd0;
  assign we = run & MemWrite & ~d_oor;
`ifdef MEM_WRITE_BYPASS_EN
  assign if_fwd = we && IF_ADDR == ADDR;
  assign d_fwd = we;
`else
  assign if_fwd = 1'b0;
  assign d_fwd = 1'b0;
`endif
  assign if_rd = if_oor ? '0 : if_fwd ? Data_in : mem[if_idx];
  assign d_rd = d_oor ? '0 : d_fwd ? Data_in : mem[d_idx];
  assign boot_word = cnt[1:0] == 2'd2 ? DATA_W'(16'h246C) :
                     cnt[1:0] == 2'd3 ? DATA_W'(16'h4881) : DATA_W'(16'h27E7);
  always_comb begin
    state_nx = state;
    cnt_nx = run ? cnt : cnt + 1'b1;
    if (state == CLEAR && &cnt) state_nx = BOOT;
    if (state == BOOT && cnt[1:0] == 2'd3) state_nx = RUN;
  end
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // The array has no reset; the sequencer owns the write port until RUN.
  always_ff @(posedge CLK)
    if (!run) mem[cnt] <= state == BOOT ? boot_word : '0;
    else if (we) mem[d_idx] <= Data_in;
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      iv <= '0;
      dv <= '0;
      addr_err <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) begin
        id[i] <= '0;
        dd[i] <= '0;
      end
    end else begin
      iv[0] <= run & IF_REQ;
      dv[0] <= run & MemRead;
      if (run & IF_REQ) id[0] <= if_rd;
      if (run & MemRead) dd[0] <= d_rd;
      for (int i = 1; i < READ_LAT; i++) begin
        iv[i] <= iv[i-1];
        dv[i] <= dv[i-1];
        if (iv[i-1]) id[i] <= id[i-1];
        if (dv[i-1]) dd[i] <= dd[i-1];
      end
      addr_err <= run & ((IF_REQ & if_oor) | ((MemRead | MemWrite) & d_oor));
    end
  assign IF_VALID = iv[READ_LAT-1];
  assign IF_DATA = id[READ_LAT-1];
  assign Data_valid = dv[READ_LAT-1];
  assign Data_out = dd[READ_LAT-1];
endmodule

// File: tb/tb_dual_port_memory.sv
// tb_dual_port_memory: two DUTs (READ_LAT 1 and 2, ADDR_W 4) on shared stimulus vs a cycle-count reference model.
module tb_dual_port_memory;
  localparam int AW = 4;
  localparam int DEPTH = 16;
`ifdef MEM_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic if_req, mem_read, mem_write;
  logic [15:0] if_addr, addr, data_in;
  logic rdy1, ifv1, dv1, err1, rdy2, ifv2, dv2, err2;
  logic [15:0] ifd1, dout1, ifd2, dout2;
  int n_chk = 0, n_fail = 0;
  logic [15:0] mm [DEPTH];
  int since;
  logic p_iv, p_dv;
  logic [15:0] p_id, p_dd;
  logic x_rdy, x_iv1, x_dv1, x_iv2, x_dv2, x_err;
  logic [15:0] x_id1, x_dd1, x_id2, x_dd2;

  dual_port_memory #(.DATA_W(16), .ADDR_W(AW), .READ_LAT(1)) u1 (
    .CLK(clk), .reset(reset), .ready(rdy1), .IF_REQ(if_req), .IF_ADDR(if_addr),
    .IF_DATA(ifd1), .IF_VALID(ifv1), .MemRead(mem_read), .MemWrite(mem_write),
    .ADDR(addr), .Data_in(data_in), .Data_out(dout1), .Data_valid(dv1), .addr_err(err1));
  dual_port_memory #(.DATA_W(16), .ADDR_W(AW), .READ_LAT(2)) u2 (
    .CLK(clk), .reset(reset), .ready(rdy2), .IF_REQ(if_req), .IF_ADDR(if_addr),
    .IF_DATA(ifd2), .IF_VALID(ifv2), .MemRead(mem_read), .MemWrite(mem_write),
    .ADDR(addr), .Data_in(data_in), .Data_out(dout2), .Data_valid(dv2), .addr_err(err2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready1", 16'(rdy1), 16'(x_rdy));
    chk("ready2", 16'(rdy2), 16'(x_rdy));
    chk("if_valid1", 16'(ifv1), 16'(x_iv1));
    chk("if_data1", ifd1, x_id1);
    chk("d_valid1", 16'(dv1), 16'(x_dv1));
    chk("d_out1", dout1, x_dd1);
    chk("if_valid2", 16'(ifv2), 16'(x_iv2));
    chk("if_data2", ifd2, x_id2);
    chk("d_valid2", 16'(dv2), 16'(x_dv2));
    chk("d_out2", dout2, x_dd2);
    chk("addr_err1", 16'(err1), 16'(x_err));
    chk("addr_err2", 16'(err2), 16'(x_err));
  endtask

  // After reset the array is expected to hold zeros plus the 4-word boot image.
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mm[i] = 16'h0;
    mm[0] = 16'h27E7; mm[1] = 16'h27E7; mm[2] = 16'h246C; mm[3] = 16'h4881;
    since = 0;
    {p_iv, p_dv, p_id, p_dd} = '0;
    {x_rdy, x_iv1, x_dv1, x_iv2, x_dv2, x_err} = '0;
    {x_id1, x_dd1, x_id2, x_dd2} = '0;
  endtask

  task automatic tick();
    logic acc, ioor, door, n_iv, n_dv, n_err, rst_at;
    logic [15:0] n_id, n_dd;
    rst_at = reset;
    acc = !reset && since >= DEPTH + 4;
    ioor = (if_addr >> AW) != 16'd0;
    door = (addr >> AW) != 16'd0;
    n_iv = acc & if_req;
    n_dv = acc & mem_read;
    n_id = ioor ? 16'h0 : (BYP && mem_write && !door && addr == if_addr) ? data_in : mm[if_addr[AW-1:0]];
    n_dd = door ? 16'h0 : (BYP && mem_write) ? data_in : mm[addr[AW-1:0]];
    n_err = acc & ((if_req & ioor) | ((mem_read | mem_write) & door));
    if (acc && mem_write && !door) mm[addr[AW-1:0]] = data_in;
    @(posedge clk);
    #1;
    if (rst_at) model_reset();
    else begin
      x_iv1 = n_iv; if (n_iv) x_id1 = n_id;
      x_dv1 = n_dv; if (n_dv) x_dd1 = n_dd;
      x_iv2 = p_iv; if (p_iv) x_id2 = p_id;
      x_dv2 = p_dv; if (p_dv) x_dd2 = p_dd;
      p_iv = n_iv; p_id = n_id; p_dv = n_dv; p_dd = n_dd;
      x_err = n_err;
      if (since < 1000) since++;
      x_rdy = since >= DEPTH + 4;
    end
    check_all();
  endtask

  task automatic idle();
    if_req = 0; mem_read = 0; mem_write = 0;
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
  endtask

  task automatic rand_req(input bool_oor);
    if_req = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
    if_addr = ($urandom_range(0, 7) == 0 || bool_oor) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
    addr = ($urandom_range(0, 7) == 0 || bool_oor) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
    if ($urandom_range(0, 3) == 0) addr = if_addr;
    data_in = 16'($urandom);
  endtask

  initial begin
    idle(); if_addr = 0; addr = 0; data_in = 0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    for (int i = 1; i <= DEPTH + 4; i++) begin
      rand_req(1'b0);
      if (i == DEPTH + 2) begin mem_write = 1; addr = 16'd2; data_in = 16'hFFFF; end
      tick();
    end
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      if_req = 1; if_addr = 16'(i); mem_read = 1; addr = 16'(DEPTH - 1 - i);
      tick();
    end
    idle(); tick(); tick();
    mem_write = 1; addr = 16'd5; data_in = 16'h1234; tick();
    idle(); mem_read = 1; tick(); tick(); tick();
    idle(); tick(); tick();
    mem_write = 1; addr = 16'd7; data_in = 16'h00AA; tick();
    data_in = 16'h0055; if_req = 1; if_addr = 16'd7; mem_read = 1; tick();
    idle(); mem_read = 1; if_req = 1; tick();
    idle(); tick(); tick();
    mem_write = 1; addr = 16'h0400; data_in = 16'hBEEF; tick();
    idle(); mem_read = 1; tick();
    idle(); if_req = 1; if_addr = 16'h8000; tick();
    if_addr = 16'h0000; tick();
    idle(); tick(); tick();
    for (int i = 0; i < 400; i++) begin rand_req(1'b0); tick(); end
    idle(); tick(); tick();
    async_reset();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_req(1'b1); tick(); end
    async_reset();
    tick();
    reset = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) begin rand_req(1'b0); tick(); end
    idle();
    mem_read = 1; addr = 16'd5; if_req = 1; if_addr = 16'd3; tick();
    idle();
    async_reset();
    tick();
    reset = 1'b0;
    for (int i = 0; i < DEPTH + 6; i++) tick();
    if_req = 1; if_addr = 16'd5; mem_read = 1; addr = 16'd2; tick();
    idle(); tick(); tick();
    for (int i = 0; i < 200; i++) begin rand_req(1'b0); tick(); end
    idle(); tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
